mem_read_dualrail_issuer: RTL and testbench

- Clocked front end that feeds the memory-data demultiplexer.
- Accepts byte-read requests tagged with a destination (instruction fetch or cache), queues them, and reads a synchronous byte memory.
- Converts each returned byte into a dual-rail (true/false) 16-bit word plus a dual-rail destination select.
- Hands each word to the asynchronous demux with a four-phase return-to-zero handshake (DATA, ack high, NULL, ack low).

---
 rtl/mem_read_dualrail_issuer.sv | 213 +++++++++++++++++++++
 tb/tb_mem_read_dualrail_issuer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_dualrail_issuer.sv
// rtl/mem_read_dualrail_issuer.sv - queued byte reads re-issued as dual-rail four-phase words to the demux
// Optional ack timeout with sticky err: define MEM_READ_ACK_TIMEOUT_EN.
module mem_read_dualrail_issuer #(
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_dest,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_rvalid,
   output logic [15:0]       data_out,
   output logic [1:0]        ph0,
   input  logic              ack_instr,
   input  logic              ack_cache,
   output logic              busy,
   output logic              err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] WAIT_HI  = 2'd2;
   localparam logic [1:0] WAIT_LO  = 2'd3;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
      $error("mem_read_dualrail_issuer: illegal parameter set");
   end

   logic [ADDR_W:0]        fifo_mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W:0]         count;
   logic [SYNC_STAGES-1:0] sync_instr;
   logic [SYNC_STAGES-1:0] sync_cache;
   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic                   push;
   logic                   pop;
   logic                   issue;
   logic                   load_data;
   logic                   go_null;
   logic                   fifo_empty;
   logic                   head_dest;
   logic [ADDR_W-1:0]      head_addr;
   logic                   ack_sel;
   logic [15:0]            enc;

   assign fifo_empty = (count == '0);
   assign req_ready  = (count != FULL_CNT);
   assign push       = req_valid && req_ready;
   assign head_addr  = fifo_mem[rd_ptr][ADDR_W-1:0];
   assign head_dest  = fifo_mem[rd_ptr][ADDR_W];
   assign ack_sel    = head_dest ? sync_cache[SYNC_STAGES-1] : sync_instr[SYNC_STAGES-1];
   assign busy       = !fifo_empty || (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_instr <= '0;
         sync_cache <= '0;
      end else begin
         sync_instr <= {sync_instr[SYNC_STAGES-2:0], ack_instr};
         sync_cache <= {sync_cache[SYNC_STAGES-2:0], ack_cache};
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {req_dest, req_addr};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // true rail on the odd bit, false rail on the even bit of each pair
   always_comb begin
      enc = '0;
      for (int i = 0; i < 8; i++) begin
         enc[2*i+1] = mem_rdata[i];
         enc[2*i]   = ~mem_rdata[i];
      end
   end

`ifdef MEM_READ_ACK_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout;
   logic             set_err;
   logic             err_q;

   assign timeout = ((state == WAIT_HI) || (state == WAIT_LO)) &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      load_data = 1'b0;
      go_null   = 1'b0;
      pop       = 1'b0;
`ifdef MEM_READ_ACK_TIMEOUT_EN
      set_err   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!fifo_empty && !ack_sel) begin
               issue     = 1'b1;
               state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (mem_rvalid) begin
               load_data = 1'b1;
               state_nxt = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (ack_sel) begin
               go_null   = 1'b1;
               state_nxt = WAIT_LO;
            end
`ifdef MEM_READ_ACK_TIMEOUT_EN
            else if (timeout) begin
               go_null   = 1'b1;
               pop       = 1'b1;
               set_err   = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
         default: begin
            if (!ack_sel) begin
               pop       = 1'b1;
               state_nxt = IDLE;
            end
`ifdef MEM_READ_ACK_TIMEOUT_EN
            else if (timeout) begin
               pop       = 1'b1;
               set_err   = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         mem_req <= issue;
         if (issue) mem_addr <= head_addr;
      end
   end

   // word and destination rails change on the same edge so no partial wavefront is seen
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         ph0      <= 2'b00;
      end else if (load_data) begin
         data_out <= enc;
         ph0      <= head_dest ? 2'b10 : 2'b01;
      end else if (go_null) begin
         data_out <= '0;
         ph0      <= 2'b00;
      end
   end

`ifdef MEM_READ_ACK_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst || (state_nxt != state)) wait_cnt <= '0;
      else if ((state == WAIT_HI) || (state == WAIT_LO)) wait_cnt <= wait_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)          err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_read_dualrail_issuer.sv
// tb/tb_mem_read_dualrail_issuer.sv - directed bench for mem_read_dualrail_issuer
// Timeout scenario switches behaviour on MEM_READ_ACK_TIMEOUT_EN.
module tb_mem_read_dualrail_issuer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [7:0]  req_addr = 8'h00;
   logic        req_dest = 1'b0;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_rvalid = 1'b0;
   logic [15:0] data_out;
   logic [1:0]  ph0;
   logic        ack_instr = 1'b0;
   logic        ack_cache = 1'b0;
   logic        busy;
   logic        err;

   int checks = 0;
   int errors = 0;
   logic [7:0] mem_table [256];

   always #5 clk = ~clk;

   mem_read_dualrail_issuer #(
      .ADDR_W(8), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYC(8)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_dest(req_dest),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .data_out(data_out), .ph0(ph0),
      .ack_instr(ack_instr), .ack_cache(ack_cache),
      .busy(busy), .err(err)
   );

   // one-cycle-latency synchronous byte memory
   always @(negedge clk) begin
      mem_rvalid = mem_req;
      mem_rdata  = mem_table[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic push(input logic [7:0] a, input logic d);
      req_valid = 1'b1;
      req_addr  = a;
      req_dest  = d;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_data(input int limit, output bit ok);
      ok = 1'b0;
      for (int n = 0; n <= limit; n++) begin
         if (ph0 != 2'b00) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      tick();
      checks++;
      if (data_out !== 16'h0000 || ph0 !== 2'b00 || mem_req !== 1'b0 || mem_addr !== 8'h00 ||
          req_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: data_out=%h ph0=%b mem_req=%b mem_addr=%h req_ready=%b busy=%b err=%b, want 0000 00 0 00 1 0 0",
                  data_out, ph0, mem_req, mem_addr, req_ready, busy, err);
      end
   endtask

   task automatic test_basic_instr();
      push(8'h10, 1'b0);
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin
         errors++;
         $display("FAIL basic_mem_req: mem_req=%b mem_addr=%h, want 1 10", mem_req, mem_addr);
      end
      tick();
      checks++;
      if (data_out !== 16'h9966 || ph0 !== 2'b01 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL basic_data: data_out=%h ph0=%b mem_req=%b, want 9966 01 0", data_out, ph0, mem_req);
      end
      ack_instr = 1'b1;
      ticks(2);
      checks++;
      if (data_out !== 16'h9966 || ph0 !== 2'b01) begin
         errors++;
         $display("FAIL basic_sync_hold: data_out=%h ph0=%b, want 9966 01", data_out, ph0);
      end
      tick();
      checks++;
      if (data_out !== 16'h0000 || ph0 !== 2'b00) begin
         errors++;
         $display("FAIL basic_null: data_out=%h ph0=%b, want 0000 00", data_out, ph0);
      end
      ack_instr = 1'b0;
      ticks(2);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_hold: busy=%b, want 1", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_done: busy=%b req_ready=%b, want 0 1", busy, req_ready);
      end
   endtask

   task automatic test_cache_select();
      ack_instr = 1'b1;
      ticks(3);
      push(8'h20, 1'b1);
      ticks(2);
      checks++;
      if (data_out !== 16'h55AA || ph0 !== 2'b10) begin
         errors++;
         $display("FAIL cache_data: data_out=%h ph0=%b, want 55aa 10", data_out, ph0);
      end
      ticks(10);
      checks++;
      if (data_out !== 16'h55AA || ph0 !== 2'b10) begin
         errors++;
         $display("FAIL cache_ignore_instr_ack: data_out=%h ph0=%b, want 55aa 10", data_out, ph0);
      end
      ack_cache = 1'b1;
      ticks(3);
      checks++;
      if (ph0 !== 2'b00 || data_out !== 16'h0000) begin
         errors++;
         $display("FAIL cache_null: data_out=%h ph0=%b, want 0000 00", data_out, ph0);
      end
      ack_cache = 1'b0;
      ticks(3);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL cache_done: busy=%b, want 0", busy);
      end
      ack_instr = 1'b0;
      ticks(3);
   endtask

   task automatic test_fifo_full();
      logic [7:0]  addrs [5];
      logic        dests [5];
      logic [15:0] words [4];
      bit          ok;
      addrs = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
      dests = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      words = '{16'h5AA5, 16'hA55A, 16'h9556, 16'h6AA9};
      for (int i = 0; i < 4; i++) push(addrs[i], dests[i]);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: req_ready=%b, want 0", req_ready);
      end
      push(addrs[4], dests[4]);
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_drop_ready: req_ready=%b, want 0", req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         wait_data(20, ok);
         checks++;
         if (!ok || data_out !== words[i] || ph0 !== (dests[i] ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL full_word%0d: seen=%b data_out=%h ph0=%b, want 1 %h %b",
                     i, ok, data_out, ph0, words[i], (dests[i] ? 2'b10 : 2'b01));
         end
         if (dests[i]) ack_cache = 1'b1;
         else          ack_instr = 1'b1;
         ticks(3);
         checks++;
         if (ph0 !== 2'b00) begin
            errors++;
            $display("FAIL full_null%0d: ph0=%b, want 00", i, ph0);
         end
         ack_cache = 1'b0;
         ack_instr = 1'b0;
      end
      ticks(10);
      checks++;
      if (busy !== 1'b0 || ph0 !== 2'b00 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_drained: busy=%b ph0=%b req_ready=%b, want 0 00 1", busy, ph0, req_ready);
      end
   endtask

   task automatic test_reset_mid_handshake();
      push(8'h30, 1'b0);
      ticks(2);
      checks++;
      if (data_out !== 16'hAAAA || ph0 !== 2'b01) begin
         errors++;
         $display("FAIL rstmid_data: data_out=%h ph0=%b, want aaaa 01", data_out, ph0);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (data_out !== 16'h0000 || ph0 !== 2'b00 || busy !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_null: data_out=%h ph0=%b busy=%b req_ready=%b mem_req=%b, want 0000 00 0 1 0",
                  data_out, ph0, busy, req_ready, mem_req);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_ack_stall();
      bit issued;
      ack_instr = 1'b1;
      ticks(3);
      push(8'h50, 1'b0);
      issued = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (mem_req !== 1'b0 || ph0 !== 2'b00) issued = 1'b1;
         tick();
      end
      checks++;
      if (issued) begin
         errors++;
         $display("FAIL stall_no_issue: issued=%b, want 0", issued);
      end
      ack_instr = 1'b0;
      ticks(3);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h50) begin
         errors++;
         $display("FAIL stall_release: mem_req=%b mem_addr=%h, want 1 50", mem_req, mem_addr);
      end
      tick();
      checks++;
      if (data_out !== 16'h9966 || ph0 !== 2'b01) begin
         errors++;
         $display("FAIL stall_data: data_out=%h ph0=%b, want 9966 01", data_out, ph0);
      end
      ack_instr = 1'b1;
      ticks(3);
      ack_instr = 1'b0;
      ticks(3);
      checks++;
      if (busy !== 1'b0 || ph0 !== 2'b00) begin
         errors++;
         $display("FAIL stall_done: busy=%b ph0=%b, want 0 00", busy, ph0);
      end
   endtask

   task automatic test_timeout();
      push(8'h60, 1'b1);
      ticks(2);
      checks++;
      if (data_out !== 16'h55AA || ph0 !== 2'b10) begin
         errors++;
         $display("FAIL timeout_data: data_out=%h ph0=%b, want 55aa 10", data_out, ph0);
      end
`ifdef MEM_READ_ACK_TIMEOUT_EN
      ticks(7);
      checks++;
      if (err !== 1'b0 || ph0 !== 2'b10) begin
         errors++;
         $display("FAIL timeout_early: err=%b ph0=%b, want 0 10", err, ph0);
      end
      tick();
      checks++;
      if (err !== 1'b1 || ph0 !== 2'b00 || data_out !== 16'h0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fire: err=%b ph0=%b data_out=%h busy=%b, want 1 00 0000 0",
                  err, ph0, data_out, busy);
      end
      push(8'h61, 1'b0);
      ticks(2);
      checks++;
      if (data_out !== 16'hA55A || ph0 !== 2'b01) begin
         errors++;
         $display("FAIL timeout_next_data: data_out=%h ph0=%b, want a55a 01", data_out, ph0);
      end
      ack_instr = 1'b1;
      ticks(3);
      ack_instr = 1'b0;
      ticks(3);
      checks++;
      if (busy !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: busy=%b err=%b, want 0 1", busy, err);
      end
`else
      ticks(20);
      checks++;
      if (err !== 1'b0 || ph0 !== 2'b10 || data_out !== 16'h55AA) begin
         errors++;
         $display("FAIL no_timeout_hold: err=%b ph0=%b data_out=%h, want 0 10 55aa", err, ph0, data_out);
      end
      ack_cache = 1'b1;
      ticks(3);
      ack_cache = 1'b0;
      ticks(3);
      checks++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout_done: busy=%b err=%b, want 0 0", busy, err);
      end
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem_table[i] = 8'h00;
      mem_table[8'h10] = 8'hA5;
      mem_table[8'h20] = 8'h0F;
      mem_table[8'h30] = 8'hFF;
      mem_table[8'h40] = 8'h3C;
      mem_table[8'h41] = 8'hC3;
      mem_table[8'h42] = 8'h81;
      mem_table[8'h43] = 8'h7E;
      mem_table[8'h44] = 8'h00;
      mem_table[8'h50] = 8'hA5;
      mem_table[8'h60] = 8'h0F;
      mem_table[8'h61] = 8'hC3;

      test_reset();
      test_basic_instr();
      test_cache_select();
      test_fifo_full();
      test_reset_mid_handshake();
      test_ack_stall();
      test_timeout();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
